// File: rtl/serial_feed_ctrl.sv
// Serial frame feeder: shifts a WIDTH-bit word MSB-first into a datapath and
// counts the ones returned on B1/B2, which arrive one cycle after I/S.
//
// state | meaning
// IDLE  | ready for a new frame, counts held from the last frame
// SHIFT | driving frame bits on I, S marks the first bit
// FLUSH | one extra cycle to collect the last datapath sample
// DONE  | result valid, waiting for res_ready
module serial_feed_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             abort,
  output logic             I,
  output logic             S,
  input  logic             B1,
  input  logic             B2,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       b1_cnt,
  output logic [3:0]       b2_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-2:0] shreg_q;
  logic [3:0]       idx_q;
  logic [3:0]       b1_q, b2_q;
  logic             i_q, s_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic b);
    return (b && v != 4'hF) ? v + 4'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
      i_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= SHIFT;
            shreg_q <= req_data[WIDTH-2:0];
            i_q     <= req_data[WIDTH-1];
            s_q     <= 1'b1;
            idx_q   <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            i_q     <= 1'b0;
            s_q     <= 1'b0;
            b1_q    <= '0;
            b2_q    <= '0;
          end else begin
            s_q <= 1'b0;
            // Cycle 0 has nothing to collect yet: the datapath is one cycle behind.
            if (idx_q != 4'd0) begin
              b1_q <= sat_inc(b1_q, B1);
              b2_q <= sat_inc(b2_q, B2);
            end
            if (idx_q == 4'(WIDTH-1)) begin
              state_q <= FLUSH;
              i_q     <= 1'b0;
            end else begin
              idx_q   <= idx_q + 4'd1;
              i_q     <= shreg_q[WIDTH-2];
              shreg_q <= shreg_q << 1;
            end
          end
        end
        FLUSH: begin
          if (abort) begin
            state_q <= IDLE;
            b1_q    <= '0;
            b2_q    <= '0;
          end else begin
            state_q <= DONE;
            b1_q    <= sat_inc(b1_q, B1);
            b2_q    <= sat_inc(b2_q, B2);
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign I         = i_q;
  assign S         = s_q;
  assign b1_cnt    = b1_q;
  assign b2_cnt    = b2_q;

endmodule

// File: tb/tb_serial_feed_ctrl.sv
// Directed bench for serial_feed_ctrl with a one-register datapath model
// (B1 = I delayed, B2 = S delayed).
module tb_serial_feed_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, req_ready, abort, I, S, B1, B2;
  logic       res_valid, res_ready, busy;
  logic [7:0] req_data;
  logic [3:0] b1_cnt, b2_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  serial_feed_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .abort(abort), .I(I), .S(S), .B1(B1), .B2(B2),
    .res_valid(res_valid), .res_ready(res_ready), .b1_cnt(b1_cnt),
    .b2_cnt(b2_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    B1 <= I;
    B2 <= S;
  end

  typedef struct {
    logic [7:0] data;
    logic [3:0] b1;
    logic [3:0] b2;
    int         hold;
    bit         abort_done;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input int e_b1, input int e_b2);
    chk({tag, " req_ready"}, int'(req_ready), 1);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " res_valid"}, int'(res_valid), 0);
    chk({tag, " I"}, int'(I), 0);
    chk({tag, " S"}, int'(S), 0);
    chk({tag, " b1_cnt"}, int'(b1_cnt), e_b1);
    chk({tag, " b2_cnt"}, int'(b2_cnt), e_b2);
  endtask

  // Accept a frame on the next edge; returns at the negedge of SHIFT cycle 0.
  task automatic accept(input logic [7:0] d);
    req_valid = 1'b1;
    req_data  = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = ~d;
    @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v);
    accept(v.data);
    for (int n = 0; n < 8; n++) begin
      if (n != 0) @(negedge clk);
      chk($sformatf("I[%0d] of %h", n, v.data), int'(I), int'(v.data[7-n]));
      chk($sformatf("S[%0d]", n), int'(S), (n == 0) ? 1 : 0);
      chk("req_ready in SHIFT", int'(req_ready), 0);
      chk("busy in SHIFT", int'(busy), 1);
      chk("res_valid in SHIFT", int'(res_valid), 0);
    end
    @(negedge clk);
    chk("I in FLUSH", int'(I), 0);
    chk("S in FLUSH", int'(S), 0);
    chk("res_valid in FLUSH", int'(res_valid), 0);
    @(negedge clk);
    chk("res_valid latency", int'(res_valid), 1);
    chk("b1_cnt", int'(b1_cnt), int'(v.b1));
    chk("b2_cnt", int'(b2_cnt), int'(v.b2));
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1;
      abort     = v.abort_done;
      @(negedge clk);
      chk("backpressure res_valid", int'(res_valid), 1);
      chk("backpressure req_ready", int'(req_ready), 0);
      chk("backpressure b1_cnt", int'(b1_cnt), int'(v.b1));
      chk("backpressure b2_cnt", int'(b2_cnt), int'(v.b2));
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    abort     = 1'b0;
    chk_idle("after res_ready", int'(v.b1), int'(v.b2));
  endtask

  initial begin
    vecs[0] = '{8'hB5, 4'd5, 4'd1, 0, 1'b0};
    vecs[1] = '{8'h00, 4'd0, 4'd1, 0, 1'b0};
    vecs[2] = '{8'hFF, 4'd8, 4'd1, 0, 1'b0};
    vecs[3] = '{8'hB5, 4'd5, 4'd1, 5, 1'b0};
    vecs[4] = '{8'h3C, 4'd4, 4'd1, 3, 1'b1};
    vecs[5] = '{8'h81, 4'd2, 4'd1, 1, 1'b0};

    rst_n = 1'b0; req_valid = 1'b1; req_data = 8'hA5; abort = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset", 0, 0);
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Abort in SHIFT cycle 3 of 8'hAA
    accept(8'hAA);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("after abort", 0, 0);
    repeat (2) @(negedge clk);
    chk("no res_valid after abort", int'(res_valid), 0);
    run_frame('{8'h0F, 4'd4, 4'd1, 0, 1'b0});

    // Reset during FLUSH with a competing request
    accept(8'hC3);
    repeat (8) @(negedge clk);
    chk("reached FLUSH busy", int'(busy), 1);
    rst_n = 1'b0; req_valid = 1'b1; req_data = 8'hFF;
    @(negedge clk);
    chk_idle("reset in FLUSH", 0, 0);
    @(negedge clk);
    chk_idle("reset held", 0, 0);
    rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk_idle("post reset", 0, 0);
    run_frame('{8'hC3, 4'd4, 4'd1, 0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
